vga_multi_line_buffer: RTL and testbench

- Generalised line-buffer stage between the line buffer controller and the frame buffer (FBUFF).
- Holds NUM_BUFFS line buffers of tiles, each filled on request with a sequential burst of FBUFF row reads over a req/rsp handshake.
- Serves one pixel per clock from the one-hot-selected buffer, indexed by tile id.
- Beyond the previous two-buffer block, adds: parametrised buffer count, an explicit tile-line index per fill, and strict request arbitration.

---
 rtl/vga_mlb_pkg.sv | 30 +++
 rtl/vga_mlb_lbuff_ram.sv | 52 +++++
 rtl/vga_multi_line_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_vga_multi_line_buffer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mlb_pkg.sv
// Shared types and helpers for the multi-line buffer: fill FSM states,
// line geometry and the fixed-priority fill arbiter.
package vga_mlb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fill_state_e;

    localparam int MAX_BUFFS  = 8;
    localparam int BUFF_IDX_W = 3;

    function automatic int rows_per_line(input int tile_per_line, input int tile_per_row);
        return tile_per_line / tile_per_row;
    endfunction

    // Lowest set bit wins, so simultaneous requests are served in index order.
    function automatic logic [BUFF_IDX_W-1:0] lowest_set(input logic [MAX_BUFFS-1:0] vec);
        logic [BUFF_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_BUFFS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = BUFF_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_mlb_lbuff_ram.sv
// One line buffer: wide row write from FBUFF, tile-granular registered read
// that returns zero whenever the read is not enabled.
module vga_mlb_lbuff_ram
    import vga_mlb_pkg::*;
#(
    parameter int PXL_WIDTH     = 12,
    parameter int TILE_PER_ROW  = 4,
    parameter int ROWS          = 40,
    parameter int TILE_ID_WIDTH = 8,
    parameter int ROW_W         = 6,
    localparam int DATA_WIDTH   = TILE_PER_ROW * PXL_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ROW_W-1:0]         wr_row,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [TILE_ID_WIDTH-1:0] rd_id,
    output logic [PXL_WIDTH-1:0]     rd_pxl
);

    logic [DATA_WIDTH-1:0] mem [ROWS];
    logic [ROW_W-1:0]      rd_row;
    logic [PXL_WIDTH-1:0]  pxl;

    always_comb begin
        rd_row = ROW_W'(rd_id / TILE_ID_WIDTH'(TILE_PER_ROW));
        pxl    = '0;
        for (int t = 0; t < TILE_PER_ROW; t++) begin
            if ((rd_id % TILE_ID_WIDTH'(TILE_PER_ROW)) == TILE_ID_WIDTH'(t)) begin
                pxl = mem[rd_row][t*PXL_WIDTH +: PXL_WIDTH];
            end
        end
    end

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pxl <= '0;
        end else begin
            rd_pxl <= rd_en ? pxl : '0;
        end
    end

endmodule

// File: rtl/vga_multi_line_buffer.sv
// NUM_BUFFS line buffers filled by FBUFF row bursts, one pixel per clock out.
// Optional underrun monitor enabled by VGA_MLB_UNDERRUN_CNT_EN.
module vga_multi_line_buffer
    import vga_mlb_pkg::*;
#(
    parameter int PXL_WIDTH        = 12,
    parameter int TILE_PER_LINE    = 160,
    parameter int TILE_PER_ROW     = 4,
    parameter int NUM_BUFFS        = 2,
    parameter int TILE_LINES       = 120,
    parameter int FBUFF_ADDR_WIDTH = 13,
    localparam int ROWS_PER_LINE    = rows_per_line(TILE_PER_LINE, TILE_PER_ROW),
    localparam int FBUFF_DATA_WIDTH = TILE_PER_ROW * PXL_WIDTH,
    localparam int TILE_ID_WIDTH    = $clog2(TILE_PER_LINE),
    localparam int LINE_IDX_WIDTH   = $clog2(TILE_LINES)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [NUM_BUFFS-1:0]        buff_fill_req_i,
    input  logic [LINE_IDX_WIDTH-1:0]   line_idx_i,
    input  logic [NUM_BUFFS-1:0]        buff_sel_i,
    input  logic [TILE_ID_WIDTH-1:0]    disp_pxl_id_i,
    input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_i,
    input  logic                        fbuff_rd_rsp_i,
    output logic [NUM_BUFFS-1:0]        buff_fill_done_o,
    output logic [PXL_WIDTH-1:0]        disp_pxl_o,
    output logic                        fbuff_rd_req_o,
    output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addra_o,
`ifdef VGA_MLB_UNDERRUN_CNT_EN
    output logic                        busy_o,
    output logic                        underrun_o,
    output logic [15:0]                 underrun_cnt_o
`else
    output logic                        busy_o
`endif
);

    localparam int ROW_W = (ROWS_PER_LINE > 1) ? $clog2(ROWS_PER_LINE) : 1;
    localparam logic [ROW_W-1:0]            LAST_ROW       = ROW_W'(ROWS_PER_LINE - 1);
    localparam logic [LINE_IDX_WIDTH:0]     TILE_LINES_EXT = (LINE_IDX_WIDTH + 1)'(TILE_LINES);
    localparam logic [TILE_ID_WIDTH:0]      TILE_LINE_EXT  = (TILE_ID_WIDTH + 1)'(TILE_PER_LINE);
    localparam logic [FBUFF_ADDR_WIDTH-1:0] ROWS_A         = FBUFF_ADDR_WIDTH'(ROWS_PER_LINE);

    if (TILE_PER_LINE % TILE_PER_ROW != 0) begin : g_chk_tile_per_row
        $fatal(1, "TILE_PER_ROW must divide TILE_PER_LINE");
    end
    if (NUM_BUFFS < 2 || NUM_BUFFS > MAX_BUFFS) begin : g_chk_num_buffs
        $fatal(1, "NUM_BUFFS must be in 2..8");
    end

    fill_state_e                 state;
    logic [BUFF_IDX_W-1:0]       fill_idx;
    logic [ROW_W-1:0]            row;
    logic [FBUFF_ADDR_WIDTH-1:0] addr;
    logic [NUM_BUFFS-1:0]        done;
    logic                        rd_req;
    logic                        busy;

    logic [NUM_BUFFS-1:0]        pending;
    logic [MAX_BUFFS-1:0]        pending_ext;
    logic [LINE_IDX_WIDTH-1:0]   line_eff;
    logic [FBUFF_ADDR_WIDTH-1:0] base_next;
    logic [NUM_BUFFS-1:0]        wr_en;
    logic [NUM_BUFFS-1:0]        rd_en;
    logic [NUM_BUFFS-1:0]        filling;
    logic                        sel_onehot;
    logic                        id_ok;
    logic [PXL_WIDTH-1:0]        rd_pxl [NUM_BUFFS];

    // Out-of-range tile lines fall back to line 0 before the base is formed.
    always_comb begin
        pending     = buff_fill_req_i & ~done;
        pending_ext = '0;
        pending_ext[NUM_BUFFS-1:0] = pending;
        line_eff    = ({1'b0, line_idx_i} >= TILE_LINES_EXT) ? '0 : line_idx_i;
        base_next   = FBUFF_ADDR_WIDTH'(line_eff) * ROWS_A;
    end

    always_comb begin
        sel_onehot = (buff_sel_i != '0) && ((buff_sel_i & (buff_sel_i - 1'b1)) == '0);
        id_ok      = {1'b0, disp_pxl_id_i} < TILE_LINE_EXT;
        for (int i = 0; i < NUM_BUFFS; i++) begin
            filling[i] = busy && (fill_idx == BUFF_IDX_W'(i));
            wr_en[i]   = (state == WAIT) && fbuff_rd_rsp_i && (fill_idx == BUFF_IDX_W'(i));
            rd_en[i]   = sel_onehot && id_ok && buff_sel_i[i];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            fill_idx <= '0;
            row      <= '0;
            addr     <= '0;
            done     <= '0;
            rd_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rd_req <= 1'b0;
            for (int i = 0; i < NUM_BUFFS; i++) begin
                if (done[i] && !buff_fill_req_i[i]) begin
                    done[i] <= 1'b0;
                end
            end
            case (state)
                IDLE: begin
                    if (|pending) begin
                        fill_idx <= lowest_set(pending_ext);
                        row      <= '0;
                        addr     <= base_next;
                        rd_req   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (fbuff_rd_rsp_i) begin
                        if (row == LAST_ROW) begin
                            // Completion wins over a same-cycle clear, so a dropped request still sees one done cycle.
                            for (int i = 0; i < NUM_BUFFS; i++) begin
                                if (fill_idx == BUFF_IDX_W'(i)) begin
                                    done[i] <= 1'b1;
                                end
                            end
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            row    <= row + 1'b1;
                            addr   <= addr + 1'b1;
                            rd_req <= 1'b1;
                            state  <= REQ;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_BUFFS; g++) begin : g_buff
        vga_mlb_lbuff_ram #(
            .PXL_WIDTH     (PXL_WIDTH),
            .TILE_PER_ROW  (TILE_PER_ROW),
            .ROWS          (ROWS_PER_LINE),
            .TILE_ID_WIDTH (TILE_ID_WIDTH),
            .ROW_W         (ROW_W)
        ) u_ram (
            .clk     (clk_i),
            .rst_n   (rstn_i),
            .wr_en   (wr_en[g]),
            .wr_row  (row),
            .wr_data (fbuff_data_i),
            .rd_en   (rd_en[g]),
            .rd_id   (disp_pxl_id_i),
            .rd_pxl  (rd_pxl[g])
        );
    end

    // At most one buffer read register is non-zero, so an OR acts as the output mux.
    always_comb begin
        disp_pxl_o = '0;
        for (int i = 0; i < NUM_BUFFS; i++) begin
            disp_pxl_o = disp_pxl_o | rd_pxl[i];
        end
    end

    assign buff_fill_done_o = done;
    assign fbuff_rd_req_o   = rd_req;
    assign fbuff_addra_o    = addr;
    assign busy_o           = busy;

`ifdef VGA_MLB_UNDERRUN_CNT_EN
    logic starved;

    assign starved = sel_onehot && ((buff_sel_i & (~done | filling)) != '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            underrun_o     <= 1'b0;
            underrun_cnt_o <= '0;
        end else begin
            underrun_o <= starved;
            if (starved && underrun_cnt_o != 16'hFFFF) begin
                underrun_cnt_o <= underrun_cnt_o + 16'd1;
            end
        end
    end
`else
    logic unused_filling;

    assign unused_filling = ^filling;
`endif

endmodule

// File: tb/tb_vga_multi_line_buffer.sv
// Randomised bench: FBUFF responder with adjustable latency, line-level model of buffer contents.
module tb_vga_multi_line_buffer;

    localparam int NB = 4, PW = 12, TPL = 160, TPR = 4, RPL = 40, TL = 120;
    localparam int AW = 13, FDW = 48, TIW = 8, LIW = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NB-1:0]   req, sel, done;
    logic [LIW-1:0]  line_idx;
    logic [TIW-1:0]  pid;
    logic [FDW-1:0]  fdata;
    logic            rsp;
    logic [PW-1:0]   disp;
    logic            rd_req;
    logic [AW-1:0]   addr;
    logic            busy;
`ifdef VGA_MLB_UNDERRUN_CNT_EN
    logic            underrun;
    logic [15:0]     ucnt;
`endif

    int errors = 0;
    int checks = 0;
    int lat = 1;
    logic [FDW-1:0] fb_mem [8192];
    int model_line [NB];
    logic [AW-1:0] addr_log [$];
    int wide_err, unstable_err;
    logic prev_req = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    vga_multi_line_buffer #(.NUM_BUFFS(NB)) dut (
        .clk_i            (clk),
        .rstn_i           (rst_n),
        .buff_fill_req_i  (req),
        .line_idx_i       (line_idx),
        .buff_sel_i       (sel),
        .disp_pxl_id_i    (pid),
        .fbuff_data_i     (fdata),
        .fbuff_rd_rsp_i   (rsp),
        .buff_fill_done_o (done),
        .disp_pxl_o       (disp),
        .fbuff_rd_req_o   (rd_req),
        .fbuff_addra_o    (addr),
`ifdef VGA_MLB_UNDERRUN_CNT_EN
        .busy_o           (busy),
        .underrun_o       (underrun),
        .underrun_cnt_o   (ucnt)
`else
        .busy_o           (busy)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [FDW-1:0] rand_word();
        logic [FDW-1:0] w;
        w[31:0]  = $urandom;
        w[47:32] = 16'($urandom);
        return w;
    endfunction

    function automatic int eff_line(input int l);
        return (l >= TL) ? 0 : l;
    endfunction

    function automatic logic [PW-1:0] exp_pxl(input int b, input int id);
        logic [FDW-1:0] w;
        w = fb_mem[model_line[b] * RPL + id / TPR];
        return w[(id % TPR) * PW +: PW];
    endfunction

    // Request log and handshake-shape observations.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rd_req === 1'b1) begin
                addr_log.push_back(addr);
                if (prev_req === 1'b1) wide_err++;
            end else if (busy === 1'b1 && addr !== prev_addr) begin
                unstable_err++;
            end
        end
        prev_req  = rd_req;
        prev_addr = addr;
    end

    // FBUFF model: one outstanding read, answered after lat cycles, garbage data otherwise.
    initial begin
        logic [AW-1:0] a;
        rsp   = 1'b0;
        fdata = '0;
        forever begin
            @(negedge clk);
            if (rd_req === 1'b1) begin
                a = addr;
                repeat (lat) @(posedge clk);
                #1;
                rsp   = 1'b1;
                fdata = fb_mem[a];
                @(posedge clk);
                #1;
                rsp   = 1'b0;
                fdata = rand_word();
            end
        end
    end

    task automatic run_fill(input int b, input int line, output int bcyc, output bit tmo);
        addr_log.delete();
        wide_err = 0;
        unstable_err = 0;
        bcyc = 0;
        tmo = 1'b1;
        line_idx = LIW'(line);
        req[b] = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (busy === 1'b1) bcyc++;
            if (done[b] === 1'b1) begin
                tmo = 1'b0;
                break;
            end
        end
        line_idx = LIW'($urandom);
        model_line[b] = eff_line(line);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; sel = '0; line_idx = '0; pid = '0;
        repeat (3) @(negedge clk);
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b, want 0", rd_req); end
        checks++; if (addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d, want 0", addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
        checks++; if (done !== '0) begin errors++; $display("FAIL reset_done: got %b, want 0", done); end
        checks++; if (disp !== '0) begin errors++; $display("FAIL reset_disp: got %h, want 0", disp); end
`ifdef VGA_MLB_UNDERRUN_CNT_EN
        checks++; if (ucnt !== 16'd0) begin errors++; $display("FAIL reset_ucnt: got %0d, want 0", ucnt); end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, want 0", busy); end
    endtask

`ifdef VGA_MLB_UNDERRUN_CNT_EN
    task automatic test_underrun();
        sel = 4'b0010;
        @(negedge clk);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse: got %b, want 1", underrun); end
        repeat (9) @(negedge clk);
        sel = '0;
        @(negedge clk);
        checks++; if (ucnt !== 16'd10) begin errors++; $display("FAIL underrun_cnt: got %0d, want 10", ucnt); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_idle: got %b, want 0", underrun); end
    endtask
`endif

    task automatic test_display(input int b, input int n);
        int id;
        logic [PW-1:0] e;
        sel = NB'(1 << b);
        for (int k = 0; k < ((n == 0) ? TPL : n); k++) begin
            id  = (n == 0) ? k : int'($urandom_range(0, TPL - 1));
            pid = TIW'(id);
            @(negedge clk);
            e = exp_pxl(b, id);
            checks++; if (disp !== e) begin errors++; $display("FAIL disp buf=%0d id=%0d: got %h, want %h", b, id, disp, e); end
        end
        for (int k = 0; k < 6; k++) begin
            pid = TIW'($urandom_range(TPL, 255));
            @(negedge clk);
            checks++; if (disp !== '0) begin errors++; $display("FAIL disp_id_range id=%0d: got %h, want 0", pid, disp); end
        end
        pid = TIW'($urandom_range(0, TPL - 1));
        sel = NB'((1 << b) | (1 << ((b + 1) % NB)));
        @(negedge clk);
        checks++; if (disp !== '0) begin errors++; $display("FAIL disp_sel_multi sel=%b: got %h, want 0", sel, disp); end
        sel = '0;
        @(negedge clk);
        checks++; if (disp !== '0) begin errors++; $display("FAIL disp_sel_zero: got %h, want 0", disp); end
    endtask

    task automatic test_single_fill();
        int bc, bad;
        bit tmo;
        lat = 1;
        run_fill(0, 0, bc, tmo);
        bad = 0;
        foreach (addr_log[k]) if (addr_log[k] !== AW'(k)) bad++;
        checks++; if (tmo) begin errors++; $display("FAIL single_timeout: done never rose"); end
        checks++; if (addr_log.size() != RPL || bad != 0) begin errors++; $display("FAIL single_addr: got %0d reqs %0d wrong, want 40 from 0", addr_log.size(), bad); end
        checks++; if (bc != 2 * RPL) begin errors++; $display("FAIL single_cycles: got %0d, want %0d", bc, 2 * RPL); end
        checks++; if (wide_err != 0) begin errors++; $display("FAIL single_req_width: got %0d wide pulses, want 0", wide_err); end
        checks++; if (done !== 4'b0001 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got done=%b busy=%b, want 0001/0", done, busy); end
        repeat (5) @(negedge clk);
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL done_hold: got %b, want 0001", done); end
        req[0] = 1'b0;
        @(negedge clk);
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL done_clear: got %b, want 0000", done); end
    endtask

    task automatic test_simultaneous();
        int t0, t1, bad;
        lat = 1;
        addr_log.delete();
        wide_err = 0;
        t0 = -1; t1 = -1;
        line_idx = 7'd5;
        req = 4'b0011;
        for (int c = 0; c < 400 && t1 < 0; c++) begin
            @(negedge clk);
            if (t0 < 0 && done[0] === 1'b1) t0 = c;
            if (t1 < 0 && done[1] === 1'b1) t1 = c;
        end
        model_line[0] = 5;
        model_line[1] = 5;
        bad = 0;
        foreach (addr_log[k]) if (addr_log[k] !== AW'(200 + k % RPL)) bad++;
        checks++; if (t0 < 0 || t1 < 0) begin errors++; $display("FAIL simul_timeout: t0=%0d t1=%0d", t0, t1); end
        checks++; if (addr_log.size() != 2 * RPL || bad != 0) begin errors++; $display("FAIL simul_addr: got %0d reqs %0d wrong, want 80 (200..239 twice)", addr_log.size(), bad); end
        checks++; if (t1 - t0 != 2 * RPL + 1) begin errors++; $display("FAIL simul_gap: got %0d cycles, want %0d", t1 - t0, 2 * RPL + 1); end
        checks++; if (wide_err != 0) begin errors++; $display("FAIL simul_req_width: got %0d, want 0", wide_err); end
        req = '0;
        repeat (2) @(negedge clk);
        test_display(1, 24);
        test_display(0, 24);
    endtask

    task automatic test_delayed_rsp();
        int bc, bad, line, base;
        bit tmo;
        lat = 4;
        line = int'($urandom_range(0, TL - 1));
        base = line * RPL;
        run_fill(2, line, bc, tmo);
        bad = 0;
        foreach (addr_log[k]) if (addr_log[k] !== AW'(base + k)) bad++;
        checks++; if (tmo) begin errors++; $display("FAIL delayed_timeout: done never rose"); end
        checks++; if (addr_log.size() != RPL || bad != 0) begin errors++; $display("FAIL delayed_addr: got %0d reqs %0d wrong, want 40 from %0d", addr_log.size(), bad, base); end
        checks++; if (bc != RPL * (lat + 1)) begin errors++; $display("FAIL delayed_cycles: got %0d, want %0d", bc, RPL * (lat + 1)); end
        checks++; if (unstable_err != 0 || wide_err != 0) begin errors++; $display("FAIL delayed_shape: got unstable=%0d wide=%0d, want 0/0", unstable_err, wide_err); end
        req[2] = 1'b0;
        repeat (2) @(negedge clk);
        test_display(2, 24);
    endtask

    task automatic test_line_wrap();
        int bc, bad;
        bit tmo;
        lat = 1;
        run_fill(3, int'($urandom_range(TL, 127)), bc, tmo);
        bad = 0;
        foreach (addr_log[k]) if (addr_log[k] !== AW'(k)) bad++;
        checks++; if (tmo || addr_log.size() != RPL || bad != 0) begin errors++; $display("FAIL wrap_addr: got tmo=%0d %0d reqs %0d wrong, want 40 from 0", tmo, addr_log.size(), bad); end
        req[3] = 1'b0;
        repeat (2) @(negedge clk);
        test_display(3, 16);
    endtask

    task automatic test_drop_midfill();
        int hi, bad, line;
        bit seen;
        lat = 2;
        line = int'($urandom_range(0, TL - 1));
        addr_log.delete();
        line_idx = LIW'(line);
        req[1] = 1'b1;
        for (int c = 0; c < 200 && addr_log.size() < 10; c++) @(negedge clk);
        req[1] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (done[1] === 1'b1) seen = 1'b1;
        end
        hi = seen ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (done[1] === 1'b1) hi++;
        end
        model_line[1] = line;
        bad = 0;
        foreach (addr_log[k]) if (addr_log[k] !== AW'(line * RPL + k)) bad++;
        checks++; if (hi != 1) begin errors++; $display("FAIL drop_done_pulse: got %0d high cycles, want 1", hi); end
        checks++; if (addr_log.size() != RPL || bad != 0) begin errors++; $display("FAIL drop_addr: got %0d reqs %0d wrong, want 40", addr_log.size(), bad); end
        test_display(1, 16);
    endtask

    task automatic test_reset_midfill();
        int line, bad;
        bit seen;
        logic [PW-1:0] e;
        lat = 1;
        line = int'($urandom_range(0, TL - 1));
        sel = 4'b0100;
        pid = TIW'($urandom_range(0, TPL - 1));
        addr_log.delete();
        line_idx = LIW'(line);
        req[0] = 1'b1;
        for (int c = 0; c < 200 && addr_log.size() < 18; c++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({rd_req, busy} !== 2'b00 || addr !== '0 || done !== '0 || disp !== '0) begin
            errors++; $display("FAIL midfill_reset: got req=%b busy=%b addr=%0d done=%b disp=%h, want all 0", rd_req, busy, addr, done, disp);
        end
        repeat (6) @(negedge clk);
        addr_log.delete();
        line_idx = LIW'(line);
        rst_n = 1'b1;
        @(negedge clk);
        e = exp_pxl(2, int'(pid));
        checks++; if (disp !== e) begin errors++; $display("FAIL contents_kept: got %h, want %h", disp, e); end
        sel = '0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (done[0] === 1'b1) seen = 1'b1;
        end
        model_line[0] = line;
        bad = 0;
        foreach (addr_log[k]) if (addr_log[k] !== AW'(line * RPL + k)) bad++;
        checks++; if (!seen || addr_log.size() != RPL || bad != 0) begin errors++; $display("FAIL restart_addr: got seen=%0d %0d reqs %0d wrong, want 40 from row 0", seen, addr_log.size(), bad); end
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        test_display(0, 16);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) fb_mem[i] = rand_word();
        for (int b = 0; b < NB; b++) model_line[b] = 0;
        test_reset();
`ifdef VGA_MLB_UNDERRUN_CNT_EN
        test_underrun();
`endif
        test_single_fill();
        test_display(0, 0);
        test_simultaneous();
        test_delayed_rsp();
        test_line_wrap();
        test_drop_midfill();
        test_reset_midfill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
